// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state, cause encodings and counter width helper for the reset sequencer
package reset_seq_pkg;
  typedef enum logic [1:0] {HOLD, RELEASE, RUN, SOFT} state_t;
  localparam logic [1:0] CAUSE_POWER  = 2'd0;
  localparam logic [1:0] CAUSE_BUTTON = 2'd1;
  localparam logic [1:0] CAUSE_SOFT   = 2'd2;
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/reset_debounce.sv
// reset_debounce: 2-FF synchroniser plus stability counter for the reset button
module reset_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic db
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  // adopt the synchronised level only after it has differed for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], button};
      if (sync[1] == db) cnt <= '0;
      else if (cnt == LAST) begin
        cnt <= '0;
        db  <= sync[1];
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds reset channels until PLL lock and button release, then releases them in order
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int RESET_CYCLES = 131071,
  parameter int STAGE_GAP = 1024,
  parameter int DEBOUNCE_CYCLES = 65535,
  parameter logic [CHANNELS-1:0] SOFT_MASK = {{(CHANNELS - 1){1'b1}}, 1'b0},
  parameter int SOFT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pll_locked,
  input  logic                button,
  input  logic                soft_req,
  input  logic [CHANNELS-1:0] ack,
  output logic [CHANNELS-1:0] nreset_out,
  output logic                busy,
  output logic [1:0]          cause
);
  localparam int IW = cnt_w(CHANNELS - 1);
  localparam int HW = cnt_w(RESET_CYCLES - 1);
  localparam int GW = cnt_w(STAGE_GAP - 1);
  localparam int SW = cnt_w(SOFT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
  localparam logic [SW-1:0] SOFT_LAST = SW'(SOFT_CYCLES - 1);

  logic [1:0] lock_sync;
  logic button_db, fatal, gap_done;
  state_t state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [SW-1:0] soft_cnt, soft_n;
  logic [IW-1:0] idx, idx_n, nxt_idx, lo_idx;
  logic [CHANNELS-1:0] seq_mask, mask_n, nrst_n;
  logic [1:0] cause_n;
  logic nxt_found, lo_found;

  reset_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_button (
    .clk(clk), .reset(reset), .button(button), .db(button_db)
  );

  // PLL lock is synchronised but deliberately not debounced: loss must act fast
  always_ff @(posedge clk or posedge reset)
    if (reset) lock_sync <= '0;
    else lock_sync <= {lock_sync[0], pll_locked};

  assign fatal    = ~lock_sync[1] | button_db;
  assign gap_done = (gap_cnt == GAP_LAST);

  // find the next channel of the active sequence after idx, and the first soft-masked channel
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    lo_found  = 1'b0;
    lo_idx    = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (seq_mask[i] && i > int'(idx)) begin
        nxt_found = 1'b1;
        nxt_idx   = IW'(i);
      end
      if (SOFT_MASK[i]) begin
        lo_found = 1'b1;
        lo_idx   = IW'(i);
      end
    end
  end

  // sequencing decisions; outputs are computed alongside the next state so they register together
  always_comb begin
    state_n = state;
    hold_n  = '0;
    gap_n   = gap_cnt;
    soft_n  = soft_cnt;
    idx_n   = idx;
    mask_n  = seq_mask;
    nrst_n  = nreset_out;
    cause_n = cause;
    if (state == HOLD) begin
      nrst_n = '0;
      hold_n = fatal ? '0 : hold_cnt + 1'b1;
      if (!fatal && hold_cnt == HOLD_LAST) begin
        state_n   = RELEASE;
        hold_n    = '0;
        idx_n     = '0;
        gap_n     = '0;
        mask_n    = '1;
        nrst_n[0] = 1'b1;
      end
    end else if (fatal) begin
      state_n = HOLD;
      nrst_n  = '0;
      cause_n = button_db ? CAUSE_BUTTON : CAUSE_POWER;
    end else if (state == RELEASE) begin
      gap_n = gap_done ? gap_cnt : gap_cnt + 1'b1;
      if (gap_done && ack[idx]) begin
        if (nxt_found) begin
          idx_n           = nxt_idx;
          gap_n           = '0;
          nrst_n[nxt_idx] = 1'b1;
        end else state_n = RUN;
      end
    end else if (state == RUN) begin
      if (soft_req) begin
        state_n = SOFT;
        soft_n  = '0;
        nrst_n  = nreset_out & ~SOFT_MASK;
        cause_n = CAUSE_SOFT;
      end
    end else begin
      soft_n = soft_cnt + 1'b1;
      if (soft_cnt == SOFT_LAST) begin
        soft_n = '0;
        mask_n = SOFT_MASK;
        if (lo_found) begin
          state_n        = RELEASE;
          idx_n          = lo_idx;
          gap_n          = '0;
          nrst_n[lo_idx] = 1'b1;
        end else state_n = RUN;
      end
    end
  end

  // state and output registers; busy tracks whether any channel will still be held
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      soft_cnt   <= '0;
      idx        <= '0;
      seq_mask   <= '1;
      nreset_out <= '0;
      busy       <= 1'b1;
      cause      <= CAUSE_POWER;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_n;
      gap_cnt    <= gap_n;
      soft_cnt   <= soft_n;
      idx        <= idx_n;
      seq_mask   <= mask_n;
      nreset_out <= nrst_n;
      busy       <= ~&nrst_n;
      cause      <= cause_n;
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed and randomized checks of reset_sequencer against a queue-based model
module tb_reset_sequencer;
  localparam int RC = 16, GAP = 4, DB = 8, SC = 5;
  localparam logic [2:0] MASK = 3'b110;

  logic clk = 1'b0, rst = 1'b1, pll_locked = 1'b0, button = 1'b0, soft_req = 1'b0;
  logic [2:0] ack = 3'b111;
  logic [2:0] nreset_out;
  logic busy;
  logic [1:0] cause;
  int errors = 0, checks = 0;

  reset_sequencer #(
    .CHANNELS(3), .RESET_CYCLES(RC), .STAGE_GAP(GAP), .DEBOUNCE_CYCLES(DB),
    .SOFT_MASK(MASK), .SOFT_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(rst), .pll_locked(pll_locked), .button(button), .soft_req(soft_req),
    .ack(ack), .nreset_out(nreset_out), .busy(busy), .cause(cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: phase 0 hold, 1 releasing from a queue of pending channels, 2 running, 3 soft hold
  bit lk1, lk2, b1, b2, mdb, mfatal;
  int run_len, hold_ok, since, cur, soft_left, phase;
  int pend[$];
  logic [2:0] m_nr;
  logic m_busy;
  logic [1:0] m_cause;

  function void rel(input int c);
    m_nr[c] = 1'b1;
    cur = c;
    since = 0;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      lk1 = 0; lk2 = 0; b1 = 0; b2 = 0; mdb = 0; run_len = 0; hold_ok = 0;
      phase = 0; pend.delete(); m_nr = '0; m_busy = 1'b1; m_cause = 2'd0;
    end else begin
      mfatal = !lk2 || mdb;
      if (phase == 0) begin
        m_nr = '0;
        if (mfatal) hold_ok = 0;
        else if (hold_ok + 1 == RC) begin
          hold_ok = 0;
          phase = 1;
          pend = {1, 2};
          rel(0);
        end else hold_ok++;
      end else if (mfatal) begin
        phase = 0;
        hold_ok = 0;
        m_nr = '0;
        m_cause = mdb ? 2'd1 : 2'd0;
      end else if (phase == 1) begin
        since++;
        if (since >= GAP && ack[cur]) begin
          if (pend.size() > 0) rel(pend.pop_front());
          else phase = 2;
        end
      end else if (phase == 2) begin
        if (soft_req) begin
          phase = 3;
          m_nr = m_nr & ~MASK;
          m_cause = 2'd2;
          soft_left = SC;
        end
      end else begin
        soft_left--;
        if (soft_left == 0) begin
          pend.delete();
          for (int c = 0; c < 3; c++) if (MASK[c]) pend.push_back(c);
          if (pend.size() == 0) phase = 2;
          else begin
            phase = 1;
            rel(pend.pop_front());
          end
        end
      end
      m_busy = (m_nr != 3'b111);
      if (b2 != mdb) begin
        run_len++;
        if (run_len == DB) begin
          mdb = b2;
          run_len = 0;
        end
      end else run_len = 0;
      b2 = b1; b1 = button; lk2 = lk1; lk1 = pll_locked;
    end
  end

  always @(negedge clk) if (!rst) begin
    check("nreset_out", 32'(nreset_out), 32'(m_nr));
    check("busy", 32'(busy), 32'(m_busy));
    check("cause", 32'(cause), 32'(m_cause));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(3);
    check("reset_nr", 32'(nreset_out), 0);
    check("reset_busy", 32'(busy), 1);
    check("reset_cause", 32'(cause), 0);
    rst = 1'b0;
    pll_locked = 1'b1;
    step(17); check("pu_c17", 32'(nreset_out), 32'b000);
    step(1);  check("pu_c18", 32'(nreset_out), 32'b001); check("pu_busy18", 32'(busy), 1);
    step(4);  check("pu_c22", 32'(nreset_out), 32'b011);
    step(4);  check("pu_c26", 32'(nreset_out), 32'b111); check("pu_busy26", 32'(busy), 0);
    check("pu_cause", 32'(cause), 0);
    step(10);
    soft_req = 1'b1;
    step(1); soft_req = 1'b0;
    check("soft_t1", 32'(nreset_out), 32'b001); check("soft_busy", 32'(busy), 1);
    check("soft_cause", 32'(cause), 2);
    step(4); check("soft_t5", 32'(nreset_out), 32'b001);
    step(1); check("soft_t6", 32'(nreset_out), 32'b011);
    step(3); check("soft_t9", 32'(nreset_out), 32'b011);
    step(1); check("soft_t10", 32'(nreset_out), 32'b111);
    step(10);
    button = 1'b1; step(5); button = 1'b0;
    step(15); check("glitch", 32'(nreset_out), 32'b111);
    button = 1'b1;
    step(10); check("press_p10", 32'(nreset_out), 32'b111);
    step(1);  check("press_p11", 32'(nreset_out), 32'b000); check("press_cause", 32'(cause), 1);
    step(1);  button = 1'b0;
    step(25); check("press_p37", 32'(nreset_out), 32'b000);
    step(1);  check("press_p38", 32'(nreset_out), 32'b001);
    step(1);  pll_locked = 1'b0;
    step(2);  check("pll_q2", 32'(nreset_out), 32'b001);
    step(1);  check("pll_q3", 32'(nreset_out), 32'b000); check("pll_cause", 32'(cause), 0);
    step(2);  pll_locked = 1'b1;
    step(17); check("relock_17", 32'(nreset_out), 32'b000);
    step(1);  check("relock_18", 32'(nreset_out), 32'b001);
    step(20);
    for (int k = 0; k < 600; k++) begin
      step(1);
      soft_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) ack = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) button = ~button;
      if (pll_locked && $urandom_range(0, 199) == 0) pll_locked = 1'b0;
      else if (!pll_locked && $urandom_range(0, 7) == 0) pll_locked = 1'b1;
    end
    step(1);
    soft_req = 1'b0; button = 1'b0; pll_locked = 1'b1; ack = 3'b111;
    step(60); check("settle", 32'(nreset_out), 32'b111);
    soft_req = 1'b1;
    step(1); soft_req = 1'b0;
    step(20); check("soft2_cause", 32'(cause), 2);
    #2 rst = 1'b1;
    #1;
    check("async_nr", 32'(nreset_out), 0);
    check("async_busy", 32'(busy), 1);
    check("async_cause", 32'(cause), 0);
    step(1);
    rst = 1'b0;
    ack = 3'b101;
    step(22); check("stall_c22", 32'(nreset_out), 32'b011);
    step(18); check("stall_c40", 32'(nreset_out), 32'b011);
    ack = 3'b111;
    step(1);  check("stall_c41", 32'(nreset_out), 32'b111); check("stall_busy", 32'(busy), 0);
    step(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
